// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache for the LC-3b memory port.
// Hits complete combinationally in IDLE; misses run an optional line write-back and then a line fill.
module l1_cache #(
   parameter int NUM_SETS  = 8,
   parameter int LINE_BITS = 128
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [15:0]          mem_address,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [1:0]           mem_byte_enable,
   input  logic [15:0]          mem_wdata,
   output logic [15:0]          mem_rdata,
   output logic                 mem_resp,
   output logic [15:0]          pmem_address,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic [LINE_BITS-1:0] pmem_wdata,
   input  logic [LINE_BITS-1:0] pmem_rdata,
   input  logic                 pmem_resp
);

   localparam int IW = $clog2(NUM_SETS);
   localparam int TW = 12 - IW;

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [NUM_SETS-1:0]    r_valid;
   logic [NUM_SETS-1:0]    r_dirty;
   logic [TW-1:0]          r_tag  [NUM_SETS];
   logic [LINE_BITS-1:0]   r_data [NUM_SETS];
   logic [TW-1:0]          r_req_tag;
   logic [IW-1:0]          r_req_idx;

   logic [IW-1:0]          w_idx;
   logic [TW-1:0]          w_tag;
   logic [2:0]             w_word;
   logic                   w_req;
   logic                   w_hit;
   logic                   w_miss;
   logic                   w_wr_hit;
   logic [LINE_BITS-1:0]   w_line;
   logic [LINE_BITS-1:0]   w_merged;
   logic                   w_unused;

   function automatic logic [LINE_BITS-1:0] merge_word(
      input logic [LINE_BITS-1:0] line,
      input logic [2:0]           word,
      input logic [1:0]           be,
      input logic [15:0]          wdata
   );
      logic [LINE_BITS-1:0] m;
      m = line;
      if (be[0]) m[{word, 4'd0} +: 8] = wdata[7:0];
      if (be[1]) m[{word, 4'd8} +: 8] = wdata[15:8];
      return m;
   endfunction

   assign w_unused = mem_address[0];
   assign w_idx    = mem_address[3+IW:4];
   assign w_tag    = mem_address[15:4+IW];
   assign w_word   = mem_address[3:1];
   assign w_req    = mem_read | mem_write;
   assign w_line   = r_data[w_idx];
   assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_miss   = (r_state == S_IDLE) && w_req && !w_hit;
   // Simultaneous read and write is treated as a write.
   assign w_wr_hit = (r_state == S_IDLE) && mem_write && w_hit;
   assign w_merged = merge_word(w_line, w_word, mem_byte_enable, mem_wdata);

   always_comb begin
      w_next       = r_state;
      mem_resp     = 1'b0;
      mem_rdata    = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (w_hit) begin
                  mem_resp  = 1'b1;
                  mem_rdata = w_line[{w_word, 4'd0} +: 16];
               end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                  w_next = S_WRITEBACK;
               end else begin
                  w_next = S_ALLOCATE;
               end
            end
         end
         S_WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {r_tag[r_req_idx], r_req_idx, 4'b0};
            pmem_wdata   = r_data[r_req_idx];
            if (pmem_resp) w_next = S_ALLOCATE;
         end
         S_ALLOCATE: begin
            pmem_read    = 1'b1;
            pmem_address = {r_req_tag, r_req_idx, 4'b0};
            if (pmem_resp) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Miss tag/index are latched so a dropped request still installs the line it started.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_valid   <= '0;
         r_dirty   <= '0;
         r_req_tag <= '0;
         r_req_idx <= '0;
      end else begin
         r_state <= w_next;
         if (w_miss) begin
            r_req_tag <= w_tag;
            r_req_idx <= w_idx;
         end
         if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
         if (r_state == S_WRITEBACK && pmem_resp) r_dirty[r_req_idx] <= 1'b0;
         if (r_state == S_ALLOCATE && pmem_resp) begin
            r_valid[r_req_idx] <= 1'b1;
            r_dirty[r_req_idx] <= 1'b0;
         end
      end
   end

   // Tag and data arrays carry no reset; validity is tracked by r_valid alone.
   always_ff @(posedge clk) begin
      if (w_wr_hit) r_data[w_idx] <= w_merged;
      if (r_state == S_ALLOCATE && pmem_resp) begin
         r_data[r_req_idx] <= pmem_rdata;
         r_tag[r_req_idx]  <= r_req_tag;
      end
   end

endmodule

// File: tb/tb_l1_cache.sv
// Bench for l1_cache: directed scenarios plus random traffic checked against a flat-memory
// reference and a per-set residency model; the bench also plays physical memory.
module tb_l1_cache;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [15:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [1:0]   mem_byte_enable;
   logic [15:0]  mem_wdata;
   logic [15:0]  mem_rdata;
   logic         mem_resp;
   logic [15:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   int n_checks = 0;
   int n_pass   = 0;

   l1_cache #(.NUM_SETS(8), .LINE_BITS(128)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   // Physical memory contents (line address -> line) and the CPU-visible word image.
   logic [127:0] pstore [int];
   logic [15:0]  refw   [int];
   bit           m_valid [8];
   bit           m_dirty [8];
   int           m_line  [8];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] init_word(input int wa);
      return 16'((wa * 40503) ^ 23130);
   endfunction

   function automatic logic [127:0] pline(input int la);
      logic [127:0] l;
      if (pstore.exists(la)) return pstore[la];
      for (int w = 0; w < 8; w++) l[w*16 +: 16] = init_word(la / 2 + w);
      return l;
   endfunction

   function automatic logic [15:0] ref_word(input int a);
      logic [127:0] l;
      if (refw.exists(a / 2)) return refw[a / 2];
      l = pline(a & 'hFFF0);
      return l[((a / 2) % 8) * 16 +: 16];
   endfunction

   function automatic logic [127:0] ref_line(input int la);
      logic [127:0] l;
      for (int w = 0; w < 8; w++) l[w*16 +: 16] = ref_word(la + 2 * w);
      return l;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 8; s++) begin
         m_valid[s] = 1'b0;
         m_dirty[s] = 1'b0;
      end
      refw.delete();
   endtask

   // Called just after a rising edge; returns just after the rising edge that ends the request.
   task automatic do_req(input logic [15:0] a, input bit rd, input bit wr, input logic [1:0] be,
                         input logic [15:0] wd, input int lat,
                         output logic [15:0] rdata, output logic [127:0] wb_d);
      int           s = (int'(a) / 16) % 8;
      int           la = int'(a) & 'hFFF0;
      bit           hit = m_valid[s] && (m_line[s] == la);
      bit           exp_wb = !hit && m_valid[s] && m_dirty[s];
      int           exp_wb_a = m_line[s];
      logic [127:0] exp_wb_d = ref_line(m_line[s]);
      int           exp_lat = hit ? 1 : (1 + (exp_wb ? lat : 0) + lat + 1);
      int           cyc = 0, n_wb = 0, n_fill = 0, cnt = 0;
      bit           both = 1'b0, done = 1'b0;
      logic [15:0]  wb_a = '0, fill_a = '0;
      logic [15:0]  cur;
      rdata = '0;
      wb_d  = '0;
      mem_address = a; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (pmem_read && pmem_write) both = 1'b1;
         if (pmem_write) begin
            cnt++;
            if (cnt == lat) begin
               cnt = 0; n_wb++; wb_a = pmem_address; wb_d = pmem_wdata;
               pstore[int'(pmem_address)] = pmem_wdata;
               pmem_resp = 1'b1;
            end
         end else if (pmem_read) begin
            cnt++;
            if (cnt == lat) begin
               cnt = 0; n_fill++; fill_a = pmem_address;
               pmem_rdata = pline(int'(pmem_address));
               pmem_resp = 1'b1;
            end
         end
         if (mem_resp) begin
            done = 1'b1;
            rdata = mem_rdata;
         end
         @(posedge clk);
         #1;
         pmem_resp = 1'b0;
      end
      mem_read = 1'b0; mem_write = 1'b0;
      chk("done", 128'(done), 128'(1));
      chk("latency", 128'(cyc), 128'(exp_lat));
      chk("wb_count", 128'(n_wb), 128'(exp_wb));
      if (exp_wb) begin
         chk("wb_addr", 128'(wb_a), 128'(exp_wb_a));
         chk("wb_data", wb_d, exp_wb_d);
      end
      chk("fill_count", 128'(n_fill), 128'(hit ? 0 : 1));
      if (!hit) chk("fill_addr", 128'(fill_a), 128'(la));
      chk("strobe_excl", 128'(both), 128'(0));
      if (rd && !wr) chk("rdata", 128'(rdata), 128'(ref_word(int'(a))));
      if (wr) begin
         cur = ref_word(int'(a));
         if (be[0]) cur[7:0]  = wd[7:0];
         if (be[1]) cur[15:8] = wd[15:8];
         refw[int'(a) / 2] = cur;
      end
      if (!hit) begin
         m_line[s]  = la;
         m_valid[s] = 1'b1;
         m_dirty[s] = 1'b0;
      end
      if (wr) m_dirty[s] = 1'b1;
   endtask

   logic [15:0]  rd_v;
   logic [127:0] wb_v;
   int           n_wait;

   initial begin
      rst_n = 1'b0;
      mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
      mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
      model_reset();
      pstore[32'h0040] = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                          16'h3333, 16'hBEEF, 16'h2233, 16'h1111};
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mem_resp", 128'(mem_resp), 128'(0));
      chk("rst_pmem_read", 128'(pmem_read), 128'(0));
      chk("rst_pmem_write", 128'(pmem_write), 128'(0));
      chk("rst_pmem_addr", 128'(pmem_address), 128'(0));
      @(posedge clk); #1;

      // Cold miss, then same-line hit with known fill data.
      do_req(16'h0040, 1'b1, 1'b0, 2'b00, 16'h0, 1, rd_v, wb_v);
      chk("t1_rdata", 128'(rd_v), 128'(16'h1111));
      do_req(16'h0044, 1'b1, 1'b0, 2'b00, 16'h0, 1, rd_v, wb_v);
      chk("t2_rdata", 128'(rd_v), 128'(16'hBEEF));
      // High-byte-only write hit, then read back.
      do_req(16'h0042, 1'b0, 1'b1, 2'b10, 16'hA5C3, 1, rd_v, wb_v);
      do_req(16'h0042, 1'b1, 1'b0, 2'b00, 16'h0, 1, rd_v, wb_v);
      chk("t3_rdata", 128'(rd_v), 128'(16'hA533));
      // Conflict on a dirty line forces write-back of the modified line.
      do_req(16'h0140, 1'b1, 1'b0, 2'b00, 16'h0, 2, rd_v, wb_v);
      chk("t4_wb_word1", 128'(wb_v[31:16]), 128'(16'hA533));

      // Reset during ALLOCATE.
      mem_address = 16'h0200; mem_read = 1'b1;
      n_wait = 0;
      @(negedge clk);
      while (!pmem_read && n_wait < 20) begin
         @(negedge clk);
         n_wait++;
      end
      chk("t5_in_alloc", 128'(pmem_read), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("t5_pmem_read", 128'(pmem_read), 128'(0));
      chk("t5_pmem_write", 128'(pmem_write), 128'(0));
      chk("t5_mem_resp", 128'(mem_resp), 128'(0));
      mem_read = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_req(16'h0200, 1'b1, 1'b0, 2'b00, 16'h0, 1, rd_v, wb_v);
      // Clean line of another tag in the set: fill only.
      do_req(16'h0080, 1'b1, 1'b0, 2'b00, 16'h0, 1, rd_v, wb_v);

      for (int i = 0; i < 250; i++) begin
         int       op;
         logic [15:0] a;
         op = $urandom_range(0, 9);
         a  = 16'($urandom) & 16'h03FE;
         do_req(a, (op < 5) || (op == 9), op >= 5, 2'($urandom), 16'($urandom),
                $urandom_range(1, 3), rd_v, wb_v);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
